// File: rtl/connect4_pkg.sv
// Shared types and board constants for the Connect Four drop/draw sequencer.
package connect4_pkg;

  localparam int NUM_COLS_DEF  = 7;
  localparam int NUM_ROWS_DEF  = 6;
  localparam int PIX_PER_BLOCK = 16;

  typedef logic [2:0] col_t;
  typedef logic [2:0] row_t;
  typedef logic [3:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PREVIEW = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FINAL   = 3'd4,
    ST_COMMIT  = 3'd5
  } state_t;

endpackage

// File: rtl/drop_draw_control_if.sv
// Request and datapath signal bundle between the game FSM, the sequencer and the VGA datapath.
interface drop_draw_control_if;
  import connect4_pkg::*;

  // Handshake: drop_req is sampled only while busy=0; once taken, busy stays high until
  // the cycle after the single drop_ack pulse (drop_reject qualifies that pulse). A request
  // raised while busy is dropped, never queued.
  logic drop_req;
  col_t drop_col;
  logic drop_player;
  logic busy;
  logic drop_ack;
  logic drop_reject;
  pix_t pixel_count;
  col_t location;
  row_t decoded_height;
  logic go;
  logic player;
  logic plot;
  logic board_full;

  modport master (
    output drop_req, drop_col, drop_player,
    input  busy, drop_ack, drop_reject, pixel_count, location, decoded_height,
           go, player, plot, board_full
  );

  modport slave (
    input  drop_req, drop_col, drop_player,
    output busy, drop_ack, drop_reject, pixel_count, location, decoded_height,
           go, player, plot, board_full
  );

endinterface

// File: rtl/column_height_tracker.sv
// Per-column fill heights: one read port, one saturating increment, and a board-full flag.
module column_height_tracker
  import connect4_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  col_t rd_col,
  output row_t rd_height,
  output logic rd_full,
  input  logic inc,
  output logic board_full
);

  row_t height_q [NUM_COLS];
  row_t height_d [NUM_COLS];

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      height_d[c] = height_q[c];
      if (inc && (int'(rd_col) == c) && (int'(height_q[c]) < NUM_ROWS)) begin
        height_d[c] = height_q[c] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_COLS; c++) height_q[c] <= '0;
    end else begin
      height_q <= height_d;
    end
  end

  // Out-of-range columns read as empty; the caller rejects them on the index alone.
  always_comb begin
    rd_height = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (int'(rd_col) == c) rd_height = height_q[c];
    end
  end

  assign rd_full = (int'(rd_height) == NUM_ROWS);

  always_comb begin
    board_full = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (int'(height_q[c]) != NUM_ROWS) board_full = 1'b0;
    end
  end

endmodule

// File: rtl/drop_draw_control.sv
// Connect Four drop sequencer: validates a column, sweeps the 16-pixel block, commits the height.
// Define DROP_PREVIEW_EN to draw a preview above the board and hold before the final draw.
module drop_draw_control
  import connect4_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int NUM_ROWS    = NUM_ROWS_DEF,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  drop_draw_control_if.slave bus,
  output state_t             dbg_state
);

  localparam pix_t PIX_LAST = pix_t'(PIX_PER_BLOCK - 1);

  state_t state_q, state_d;
  pix_t   pix_q, pix_d;
  col_t   loc_q, loc_d;
  row_t   dh_q, dh_d;
  logic   player_q, player_d;
  logic   go_q, go_d;
  logic   inc_c, ack_c, reject_c, plot_c;
  row_t   rd_height;
  logic   rd_full, board_full, col_bad;

`ifdef DROP_PREVIEW_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (HOLD_CYCLES > 0);
`endif

  column_height_tracker #(
    .NUM_COLS (NUM_COLS),
    .NUM_ROWS (NUM_ROWS)
  ) u_heights (
    .clk        (clk),
    .resetn     (resetn),
    .rd_col     (loc_q),
    .rd_height  (rd_height),
    .rd_full    (rd_full),
    .inc        (inc_c),
    .board_full (board_full)
  );

  assign col_bad = (int'(loc_q) >= NUM_COLS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pix_q    <= '0;
      loc_q    <= '0;
      dh_q     <= '0;
      player_q <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      loc_q    <= loc_d;
      dh_q     <= dh_d;
      player_q <= player_d;
      go_q     <= go_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    loc_d    = loc_q;
    dh_d     = dh_q;
    player_d = player_q;
    go_d     = go_q;
    inc_c    = 1'b0;
    ack_c    = 1'b0;
    reject_c = 1'b0;
    plot_c   = 1'b0;
`ifdef DROP_PREVIEW_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.drop_req) begin
          loc_d    = bus.drop_col;
          player_d = bus.drop_player;
          go_d     = 1'b0;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (col_bad || rd_full) begin
          ack_c    = 1'b1;
          reject_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          dh_d  = rd_height;
          pix_d = '0;
`ifdef DROP_PREVIEW_EN
          state_d = ST_PREVIEW;
`else
          go_d    = 1'b1;
          state_d = ST_FINAL;
`endif
        end
      end
`ifdef DROP_PREVIEW_EN
      ST_PREVIEW: begin
        plot_c = 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      ST_HOLD: begin
        if (int'(hold_q) == HOLD_CYCLES - 1) begin
          go_d    = 1'b1;
          state_d = ST_FINAL;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
`endif
      ST_FINAL: begin
        plot_c = 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          state_d = ST_COMMIT;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      ST_COMMIT: begin
        inc_c   = 1'b1;
        ack_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.drop_ack       = ack_c;
  assign bus.drop_reject    = reject_c;
  assign bus.pixel_count    = pix_q;
  assign bus.location       = loc_q;
  assign bus.decoded_height = dh_q;
  assign bus.go             = go_q;
  assign bus.player         = player_q;
  assign bus.plot           = plot_c;
  assign bus.board_full     = board_full;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_drop_draw_control.sv
// Self-checking bench for drop_draw_control against a per-drop trace model of column heights.
module tb_drop_draw_control;
  import connect4_pkg::*;

  localparam int NC   = 7;
  localparam int NR   = 6;
  localparam int HOLD = 8;

  logic   clk;
  logic   resetn;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;
  int     heights [NC];
  logic [5:0] exp_q [$];

  drop_draw_control_if bus ();

  drop_draw_control #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_full();
    for (int c = 0; c < NC; c++) if (heights[c] != NR) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},   bus.busy, 0);
    check_val({tag, "_ack"},    {bus.drop_ack, bus.drop_reject}, 0);
    check_val({tag, "_pix"},    bus.pixel_count, 0);
    check_val({tag, "_loc"},    bus.location, 0);
    check_val({tag, "_dh"},     bus.decoded_height, 0);
    check_val({tag, "_go"},     bus.go, 0);
    check_val({tag, "_player"}, bus.player, 0);
    check_val({tag, "_plot"},   bus.plot, 0);
    check_val({tag, "_full"},   bus.board_full, 0);
    check_val({tag, "_state"},  dbg_state, ST_IDLE);
  endtask

  // Driver + checker for one request; entered and left at a negedge inside an IDLE cycle.
  task automatic do_drop(input int col, input bit pl, input bit hold_req);
    bit acc;
    bit first;
    logic [5:0] e;
    acc = (col < NC) && (heights[col % 8 < NC ? col : 0] < NR);
    bus.drop_req    = 1'b1;
    bus.drop_col    = col[2:0];
    bus.drop_player = pl;
    @(posedge clk);
    @(negedge clk);
    if (!hold_req) bus.drop_req = 1'b0;
    else bus.drop_col = col_t'(col + 1);
    check_val("loc", bus.location, col[2:0]);
    check_val("player", bus.player, pl);
    check_val("busy_check", bus.busy, 1);
    if (!acc) begin
      check_val("reject_ack", {bus.drop_ack, bus.drop_reject, bus.plot}, 3'b110);
      @(negedge clk);
      check_val("reject_idle", {bus.busy, bus.drop_ack, bus.plot}, 0);
      return;
    end
    check_val("check_noack", {bus.drop_ack, bus.plot}, 0);
`ifdef DROP_PREVIEW_EN
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 1'b0, 4'(i)});
    for (int i = 0; i < HOLD; i++) exp_q.push_back(6'b0);
`endif
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 1'b1, 4'(i)});
    first = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_val("sweep", {bus.plot, bus.go, bus.pixel_count}, e);
      check_val("sweep_ack", {bus.busy, bus.drop_ack}, 2'b10);
      if (first) check_val("dec_height", bus.decoded_height, heights[col]);
      if (hold_req) check_val("loc_stable", bus.location, col[2:0]);
      first = 1'b0;
    end
    @(negedge clk);
    check_val("commit_ack", {bus.busy, bus.drop_ack, bus.drop_reject, bus.plot, bus.go}, 5'b11001);
    heights[col]++;
    @(negedge clk);
    check_val("post_idle", {bus.busy, bus.drop_ack, bus.go}, 3'b001);
    check_val("board_full", bus.board_full, model_full());
  endtask

  initial begin
    int fs;
    for (int c = 0; c < NC; c++) heights[c] = 0;
    resetn          = 1'b0;
    bus.drop_req    = 1'b0;
    bus.drop_col    = '0;
    bus.drop_player = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // first drop: column 3, player 1
    do_drop(3, 1'b1, 1'b0);

    // fill column 0, then one more is rejected
    for (int k = 0; k < 6; k++) do_drop(0, k[0], 1'b0);
    do_drop(0, 1'b0, 1'b0);

    // illegal column
    do_drop(7, 1'b1, 1'b0);

    // request held through the sweep; back-to-back relatch after the ack
    do_drop(4, 1'b0, 1'b1);
    do_drop(4, 1'b1, 1'b0);

    // reset during FINAL pixel 9 clears everything, including column 0
`ifdef DROP_PREVIEW_EN
    fs = 2 + 16 + HOLD;
`else
    fs = 2;
`endif
    bus.drop_req = 1'b1;
    bus.drop_col = 3'd5;
    bus.drop_player = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.drop_req = 1'b0;
    repeat (fs + 8) @(negedge clk);
    check_val("mid_final", {bus.plot, bus.go, bus.pixel_count}, {1'b1, 1'b1, 4'd9});
    #2 resetn = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < NC; c++) heights[c] = 0;
    @(negedge clk);
    do_drop(0, 1'b0, 1'b0);
    do_drop(5, 1'b1, 1'b0);

    // random requests
    for (int k = 0; k < 25; k++) begin
      do_drop($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    // fill the remaining slots, then the full board rejects everything
    for (int c = 0; c < NC; c++) begin
      while (heights[c] < NR) do_drop(c, 1'($urandom_range(0, 1)), 1'b0);
    end
    check_val("final_full", bus.board_full, 1);
    do_drop($urandom_range(0, NC - 1), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
